// File: rtl/calc_seq_engine.sv
// calc_seq_engine
//   Sequential calculator engine between board buttons/switches and the display.
//   The user steps through operand A, operand B and opcode entry. The selected
//   operation is then computed, and the answer is shown.
//   Each button passes through a synchroniser, a debouncer and an edge detector,
//   which turns it into a single-cycle pulse.
//   Multiply uses shift-add and divide/modulo use restoring division, each
//   taking WIDTH cycles. All other operations finish in one cycle.
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   btn_prev, btn_next  raw asynchronous push buttons
//   sw, op_sel          operand switches and opcode entry
//   num_a, num_b        latched operands
//   op_code             latched opcode
//   stage               0 ENTER_A, 1 ENTER_B, 2 ENTER_OP, 3 COMPUTE, 4 SHOW
//   result              2*WIDTH-bit answer, updated only on completion
//   is_negative         SUB gave a negative value (result holds magnitude)
//   div_by_zero         DIV/MOD attempted with num_b == 0
//   busy, done          busy in COMPUTE; done pulses once on COMPUTE->SHOW
module calc_seq_engine #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_prev,
    input  logic                 btn_next,
    input  logic [WIDTH-1:0]     sw,
    input  logic [2:0]           op_sel,
    output logic [WIDTH-1:0]     num_a,
    output logic [WIDTH-1:0]     num_b,
    output logic [2:0]           op_code,
    output logic [2:0]           stage,
    output logic [2*WIDTH-1:0]   result,
    output logic                 is_negative,
    output logic                 div_by_zero,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned CntW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned IterW = $clog2(WIDTH);
    localparam logic [CntW-1:0]  CntMax   = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [IterW-1:0] IterLast = IterW'(WIDTH - 1);

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpMul = 3'd2;
    localparam logic [2:0] OpDiv = 3'd3;
    localparam logic [2:0] OpMod = 3'd4;
    localparam logic [2:0] OpAnd = 3'd5;
    localparam logic [2:0] OpOr  = 3'd6;
    localparam logic [2:0] OpXor = 3'd7;

    typedef enum logic [2:0] {
        StEnterA  = 3'd0,
        StEnterB  = 3'd1,
        StEnterOp = 3'd2,
        StCompute = 3'd3,
        StShow    = 3'd4
    } stage_e;

    // ---------------- button conditioning (bit 0 = prev, bit 1 = next) ----------------
    logic [1:0]           raw;
    logic [1:0]           sync1_q, sync2_q;
    logic [1:0]           level_q, level_d, level_dly_q;
    logic [1:0][CntW-1:0] cnt_q, cnt_d;
    logic [1:0]           pulse;
    logic                 prev_p, next_p;

    assign raw = {btn_next, btn_prev};

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign pulse  = level_q & ~level_dly_q;
    // Simultaneous prev+next cancel each other.
    assign prev_p = pulse[0] & ~pulse[1];
    assign next_p = pulse[1] & ~pulse[0];

    // ---------------- stage sequencer and datapath ----------------
    stage_e               stage_q, stage_d;
    logic [WIDTH-1:0]     num_a_q, num_a_d, num_b_q, num_b_d;
    logic [2:0]           op_code_q, op_code_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 neg_q, neg_d, dbz_q, dbz_d, done_q, done_d;
    logic [IterW-1:0]     iter_q, iter_d;
    // acc: MUL partial product / DIV remainder; mcand: shifted multiplicand;
    // quo: MUL multiplier bits / DIV dividend-in, quotient-out shift register.
    logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]     quo_q, quo_d;

    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH:0]       rem_sh, rem_trial, rem_n;
    logic                 rem_ge;
    logic [WIDTH-1:0]     quo_n;
    logic                 fin;
    logic [2*WIDTH-1:0]   fin_val;

    always_comb begin
        acc_sum   = acc_q + (quo_q[0] ? mcand_q : '0);
        rem_sh    = {acc_q[WIDTH-1:0], quo_q[WIDTH-1]};
        rem_trial = rem_sh - {1'b0, num_b_q};
        rem_ge    = (rem_sh >= {1'b0, num_b_q});
        rem_n     = rem_ge ? rem_trial : rem_sh;
        quo_n     = {quo_q[WIDTH-2:0], rem_ge};
    end

    always_comb begin
        stage_d   = stage_q;
        num_a_d   = num_a_q;
        num_b_d   = num_b_q;
        op_code_d = op_code_q;
        result_d  = result_q;
        neg_d     = neg_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        iter_d    = iter_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        quo_d     = quo_q;
        fin       = 1'b0;
        fin_val   = '0;

        unique case (stage_q)
            StEnterA: begin
                if (next_p) begin
                    num_a_d = sw;
                    stage_d = StEnterB;
                end
            end
            StEnterB: begin
                if (next_p) begin
                    num_b_d = sw;
                    stage_d = StEnterOp;
                end else if (prev_p) begin
                    stage_d = StEnterA;
                end
            end
            StEnterOp: begin
                if (next_p) begin
                    op_code_d = op_sel;
                    stage_d   = StCompute;
                    neg_d     = 1'b0;
                    dbz_d     = 1'b0;
                    iter_d    = '0;
                    acc_d     = '0;
                    mcand_d   = {{WIDTH{1'b0}}, num_a_q};
                    quo_d     = (op_sel == OpMul) ? num_b_q : num_a_q;
                end else if (prev_p) begin
                    stage_d = StEnterB;
                end
            end
            StCompute: begin
                iter_d = iter_q + 1'b1;
                unique case (op_code_q)
                    OpAdd: begin
                        fin     = 1'b1;
                        fin_val = {{WIDTH{1'b0}}, num_a_q} + {{WIDTH{1'b0}}, num_b_q};
                    end
                    OpSub: begin
                        fin = 1'b1;
                        if (num_a_q >= num_b_q) begin
                            fin_val = {{WIDTH{1'b0}}, num_a_q - num_b_q};
                        end else begin
                            fin_val = {{WIDTH{1'b0}}, num_b_q - num_a_q};
                            neg_d   = 1'b1;
                        end
                    end
                    OpMul: begin
                        acc_d   = acc_sum;
                        mcand_d = mcand_q << 1;
                        quo_d   = quo_q >> 1;
                        fin     = (iter_q == IterLast);
                        fin_val = acc_sum;
                    end
                    OpDiv, OpMod: begin
                        if (num_b_q == '0) begin
                            fin     = 1'b1;
                            fin_val = '0;
                            dbz_d   = 1'b1;
                        end else begin
                            acc_d   = {{(WIDTH-1){1'b0}}, rem_n};
                            quo_d   = quo_n;
                            fin     = (iter_q == IterLast);
                            fin_val = (op_code_q == OpDiv) ? {{WIDTH{1'b0}}, quo_n}
                                                           : {{(WIDTH-1){1'b0}}, rem_n};
                        end
                    end
                    OpAnd: begin
                        fin     = 1'b1;
                        fin_val = {{WIDTH{1'b0}}, num_a_q & num_b_q};
                    end
                    OpOr: begin
                        fin     = 1'b1;
                        fin_val = {{WIDTH{1'b0}}, num_a_q | num_b_q};
                    end
                    OpXor: begin
                        fin     = 1'b1;
                        fin_val = {{WIDTH{1'b0}}, num_a_q ^ num_b_q};
                    end
                    default: ;
                endcase
                if (fin) begin
                    result_d = fin_val;
                    stage_d  = StShow;
                    done_d   = 1'b1;
                end
            end
            StShow: begin
                if (next_p) begin
                    stage_d = StEnterA;
                end else if (prev_p) begin
                    stage_d = StEnterOp;
                end
            end
            default: stage_d = StEnterA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            cnt_q       <= '0;
            stage_q     <= StEnterA;
            num_a_q     <= '0;
            num_b_q     <= '0;
            op_code_q   <= '0;
            result_q    <= '0;
            neg_q       <= 1'b0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
            iter_q      <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            quo_q       <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            num_a_q     <= num_a_d;
            num_b_q     <= num_b_d;
            op_code_q   <= op_code_d;
            result_q    <= result_d;
            neg_q       <= neg_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
            iter_q      <= iter_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            quo_q       <= quo_d;
        end
    end

    assign num_a       = num_a_q;
    assign num_b       = num_b_q;
    assign op_code     = op_code_q;
    assign stage       = stage_q;
    assign result      = result_q;
    assign is_negative = neg_q;
    assign div_by_zero = dbz_q;
    assign busy        = (stage_q == StCompute);
    assign done        = done_q;

endmodule

// File: tb/tb_calc_seq_engine.sv
// Bench for calc_seq_engine (WIDTH=16, DEBOUNCE_CYCLES=4).
// A behavioural model tracks stage/operands/result from button-press events.
// A clean press whose raw edge is first sampled at edge N acts at edge N+6.
// The model is compared with the DUT every cycle. Directed scenarios add
// literal checks on top of that comparison.
module tb_calc_seq_engine;
    localparam int W = 16;
    localparam int D = 4;
    localparam int Lat = 2 + D + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           btn_prev = 1'b0;
    logic           btn_next = 1'b0;
    logic [W-1:0]   sw = '0;
    logic [2:0]     op_sel = '0;
    logic [W-1:0]   num_a, num_b;
    logic [2:0]     op_code, stage;
    logic [2*W-1:0] result;
    logic           is_negative, div_by_zero, busy, done;

    calc_seq_engine #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .btn_prev(btn_prev), .btn_next(btn_next),
        .sw(sw), .op_sel(op_sel), .num_a(num_a), .num_b(num_b), .op_code(op_code),
        .stage(stage), .result(result), .is_negative(is_negative),
        .div_by_zero(div_by_zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    bit rand_sw = 1'b0;
    bit next_at[int];
    bit prev_at[int];
    int busy_cycles = 0;
    int done_count = 0;

    // model state
    int             m_stage = 0;
    logic [W-1:0]   m_a = '0, m_b = '0;
    logic [2:0]     m_op = '0;
    logic [2*W-1:0] m_res = '0;
    bit             m_neg = 0, m_dbz = 0, m_done = 0;
    int             m_left = 0;

    function automatic logic [2*W-1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op, output bit neg,
                                            output bit dbz);
        longint unsigned la = 64'(a);
        longint unsigned lb = 64'(b);
        neg = 0;
        dbz = 0;
        case (op)
            3'd0: return (2*W)'(la + lb);
            3'd1: begin
                if (la >= lb) return (2*W)'(la - lb);
                neg = 1;
                return (2*W)'(lb - la);
            end
            3'd2: return (2*W)'(la * lb);
            3'd3: begin
                if (lb == 0) begin dbz = 1; return '0; end
                return (2*W)'(la / lb);
            end
            3'd4: begin
                if (lb == 0) begin dbz = 1; return '0; end
                return (2*W)'(la % lb);
            end
            3'd5: return (2*W)'(la & lb);
            3'd6: return (2*W)'(la | lb);
            default: return (2*W)'(la ^ lb);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model update and compare, 1 time unit after each rising edge.
    initial forever begin
        bit pn, pp, ng, dz;
        logic [2*W-1:0] r;
        @(posedge clk);
        #1;
        cyc++;
        pn = next_at.exists(cyc);
        pp = prev_at.exists(cyc);
        if (!rst_n) begin
            m_stage = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0;
            m_neg = 0; m_dbz = 0; m_done = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_stage == 3) begin
                m_left--;
                if (m_left == 0) begin
                    r = calc(m_a, m_b, m_op, ng, dz);
                    m_res = r; m_neg = ng; m_dbz = dz; m_done = 1; m_stage = 4;
                end
            end else if (pn && !pp) begin
                case (m_stage)
                    0: begin m_a = sw; m_stage = 1; end
                    1: begin m_b = sw; m_stage = 2; end
                    2: begin
                        m_op = op_sel; m_stage = 3; m_neg = 0; m_dbz = 0;
                        m_left = (op_sel == 3'd2 || ((op_sel == 3'd3 || op_sel == 3'd4)
                                  && m_b != 0)) ? W : 1;
                    end
                    default: m_stage = 0;
                endcase
            end else if (pp && !pn) begin
                if (m_stage == 1) m_stage = 0;
                else if (m_stage == 2) m_stage = 1;
                else if (m_stage == 4) m_stage = 2;
            end
        end
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) done_count++;
        if (chk_en) begin
            checks++;
            if (stage !== 3'(m_stage) || num_a !== m_a || num_b !== m_b || op_code !== m_op ||
                result !== m_res || is_negative !== m_neg || div_by_zero !== m_dbz ||
                busy !== (m_stage == 3) || done !== m_done) begin
                errors++;
                $display("FAIL model cyc %0d: got st=%0d a=%h b=%h op=%0d r=%h n=%b z=%b bs=%b d=%b exp st=%0d a=%h b=%h op=%0d r=%h n=%b z=%b d=%b",
                         cyc, stage, num_a, num_b, op_code, result, is_negative, div_by_zero,
                         busy, done, m_stage, m_a, m_b, m_op, m_res, m_neg, m_dbz, m_done);
            end
        end
    end

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rand_sw) begin
                sw = pick();
                op_sel = 3'($urandom_range(0, 7));
            end
        end
    endtask

    task automatic raise(input bit nx, input bit pv);
        if (nx) begin btn_next = 1'b1; next_at[cyc + Lat] = 1'b1; end
        if (pv) begin btn_prev = 1'b1; prev_at[cyc + Lat] = 1'b1; end
    endtask

    task automatic press(input bit nx, input bit pv);
        tick(1);
        raise(nx, pv);
        tick(6);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(10);
    endtask

    task automatic wait_show(input string name);
        int i;
        for (i = 0; i < 80; i++) begin
            if (stage == 3'd4) break;
            tick(1);
        end
        check({name, " reach SHOW"}, 64'(stage), 64'd4);
    endtask

    initial begin
        int d0, b0;
        bit ng, dz;
        // model sanity on hand-computed values
        check("model sub", 64'(calc(16'd5, 16'd9, 3'd1, ng, dz)), 64'd4);
        check("model sub neg", 64'(ng), 64'd1);
        check("model mul", 64'(calc(16'hFFFF, 16'hFFFF, 3'd2, ng, dz)), 64'hFFFE_0001);
        check("model mod", 64'(calc(16'd100, 16'd7, 3'd4, ng, dz)), 64'd2);

        tick(3);
        check("reset stage", 64'(stage), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset flags", 64'({num_a, num_b, op_code, is_negative, div_by_zero, busy, done}),
              64'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick(4);

        // Bouncy next press
        sw = 16'h1234;
        tick(1); btn_next = 1'b1;
        tick(1); btn_next = 1'b0;
        tick(1); raise(1, 0);
        tick(20); btn_next = 1'b0;
        tick(10);
        check("bounce stage", 64'(stage), 64'd1);
        check("bounce num_a", 64'(num_a), 64'h1234);

        // SUB negative
        press(0, 1);
        sw = 16'd5; press(1, 0);
        sw = 16'd9; press(1, 0);
        op_sel = 3'd1; d0 = done_count;
        press(1, 0);
        wait_show("sub");
        check("sub result", 64'(result), 64'd4);
        check("sub negative", 64'(is_negative), 64'd1);
        check("sub done pulses", 64'(done_count - d0), 64'd1);

        // Navigation
        press(1, 0);
        sw = 16'd100; press(1, 0);
        sw = 16'd7; press(1, 0);
        press(0, 1);
        check("prev to ENTER_B", 64'(stage), 64'd1);
        check("num_a kept", 64'(num_a), 64'd100);
        press(1, 1);
        check("prev+next ignored", 64'(stage), 64'd1);
        press(1, 0);

        // DIV / MOD / divide by zero
        op_sel = 3'd3; press(1, 0);
        wait_show("div");
        check("div result", 64'(result), 64'd14);
        press(0, 1);
        op_sel = 3'd4; press(1, 0);
        wait_show("mod");
        check("mod result", 64'(result), 64'd2);
        press(0, 1); press(0, 1);
        sw = 16'd0; press(1, 0);
        op_sel = 3'd3; b0 = busy_cycles;
        press(1, 0);
        check("dbz stage", 64'(stage), 64'd4);
        check("dbz result", 64'(result), 64'd0);
        check("dbz flag", 64'(div_by_zero), 64'd1);
        check("dbz busy cycles", 64'(busy_cycles - b0), 64'd1);

        // MUL max, with a press landing while busy
        press(1, 0);
        sw = 16'hFFFF; press(1, 0); press(1, 0);
        op_sel = 3'd2; b0 = busy_cycles;
        tick(1); raise(1, 0);
        tick(6); btn_next = 1'b0;
        tick(9); raise(1, 0);
        tick(6); btn_next = 1'b0;
        tick(10);
        wait_show("mul");
        check("mul result", 64'(result), 64'hFFFE_0001);
        check("mul busy cycles", 64'(busy_cycles - b0), 64'd16);
        check("mul busy press ignored", 64'(stage), 64'd4);

        // Reset at cycle 8 of a MUL
        press(1, 0);
        sw = 16'd300; press(1, 0);
        sw = 16'd21; press(1, 0);
        op_sel = 3'd2; d0 = done_count;
        tick(1); raise(1, 0);
        tick(6); btn_next = 1'b0;
        tick(8); rst_n = 1'b0;
        tick(1); rst_n = 1'b1;
        check("mid-mul reset stage", 64'(stage), 64'd0);
        check("mid-mul reset outs", 64'({num_a, num_b, op_code, result, is_negative,
              div_by_zero, busy, done}), 64'd0);
        tick(30);
        check("mid-mul reset no done", 64'(done_count - d0), 64'd0);

        // Random navigation / operations
        rand_sw = 1'b1;
        for (int k = 0; k < 80; k++) begin
            int s = int'($urandom_range(0, 9));
            if (s == 0) press(1, 1);
            else if (s <= 2) press(0, 1);
            else press(1, 0);
            if ($urandom_range(0, 3) == 0) tick(int'($urandom_range(1, 20)));
        end
        rand_sw = 1'b0;
        tick(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
